// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Receives a framed byte stream (sync, 16-bit length, 16-bit words high byte
// first, XOR checksum), writes each word into instruction memory and keeps
// the CPU pipeline held until a good image has been fully written.
module imem_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        SYNC,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_len;
    logic [15:0] r_count;
    logic [7:0]  r_cksum;
    logic [7:0]  r_word_hi;
    logic        r_rx_ready;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_error;

    logic        w_fire;
    logic [15:0] w_len;

    assign w_fire = rx_valid && r_rx_ready;
    // Full length as it stands once the low length byte is on rx_data.
    assign w_len  = {r_len[15:8], rx_data};

    // Next-state decode: advances only on an accepted byte or on restart.
    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            SYNC:    if (w_fire && rx_data == SYNC_BYTE) w_state_next = LEN_HI;
            LEN_HI:  if (w_fire) w_state_next = LEN_LO;
            LEN_LO: begin
                if (w_fire) begin
                    if (w_len == 16'd0)          w_state_next = CHECK;
                    else if (w_len > MAX_WORDS)  w_state_next = ERROR;
                    else                         w_state_next = DATA_HI;
                end
            end
            DATA_HI: if (w_fire) w_state_next = DATA_LO;
            DATA_LO: begin
                // r_len is non-zero here, so count+1 cannot wrap past it.
                if (w_fire) begin
                    if (r_count + 16'd1 == r_len) w_state_next = CHECK;
                    else                          w_state_next = DATA_HI;
                end
            end
            CHECK: begin
                if (w_fire) w_state_next = (rx_data == r_cksum) ? DONE : ERROR;
            end
            DONE:    if (restart) w_state_next = SYNC;
            ERROR:   if (restart) w_state_next = SYNC;
            default: w_state_next = SYNC;
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the
    // next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sync reset clears every register here, including a write strobe set by the same edge.
            r_state     <= SYNC;
            r_len       <= 16'd0;
            r_count     <= 16'd0;
            r_cksum     <= 8'd0;
            r_word_hi   <= 8'd0;
            r_rx_ready  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 16'd0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_state    <= w_state_next;
            r_rx_ready <= (w_state_next != DONE) && (w_state_next != ERROR);
            r_cpu_hold <= (w_state_next != DONE);
            r_done     <= (w_state_next == DONE);
            r_error    <= (w_state_next == ERROR);
            r_mem_we   <= 1'b0;

            unique case (r_state)
                LEN_HI: begin
                    if (w_fire) begin
                        r_len[15:8] <= rx_data;
                        r_cksum     <= r_cksum ^ rx_data;
                    end
                end
                LEN_LO: begin
                    if (w_fire) begin
                        r_len[7:0] <= rx_data;
                        r_cksum    <= r_cksum ^ rx_data;
                    end
                end
                DATA_HI: begin
                    if (w_fire) begin
                        r_word_hi <= rx_data;
                        r_cksum   <= r_cksum ^ rx_data;
                    end
                end
                DATA_LO: begin
                    if (w_fire) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_count;
                        r_mem_wdata <= {r_word_hi, rx_data};
                        r_count     <= r_count + 16'd1;
                        r_cksum     <= r_cksum ^ rx_data;
                    end
                end
                DONE, ERROR: begin
                    if (restart) begin
                        r_len   <= 16'd0;
                        r_count <= 16'd0;
                        r_cksum <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready  = r_rx_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: an image-level reference model that
// parses the accepted byte stream by byte position, a per-cycle compare
// process, and directed streams with hand-computed expectations.
module tb_imem_loader;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [15:0] MAX_WORDS = 16'd1024;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(.SYNC_BYTE(SYNC_BYTE), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (image-level) ----------------
    // m_out: 0 = loading (ready), 1 = image good, 2 = image rejected.
    int          m_out = 0;
    bit          m_in_image = 1'b0;
    int          m_idx = 0;
    int          m_len = 0;
    logic [7:0]  m_len_hi = 8'd0;
    logic [7:0]  m_sum = 8'd0;
    logic [7:0]  m_hi = 8'd0;
    int          exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [15:0] m_last_addr = 16'd0;
    logic [15:0] m_last_data = 16'd0;

    task automatic model_clear();
        m_out = 0;
        m_in_image = 1'b0;
        m_idx = 0;
        m_len = 0;
        m_sum = 8'd0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_clear();
            exp_addr_q.delete();
            exp_data_q.delete();
            m_last_addr = 16'd0;
            m_last_data = 16'd0;
        end else if (m_out != 0) begin
            if (restart) model_clear();
        end else if (rx_valid) begin
            if (!m_in_image) begin
                if (rx_data == SYNC_BYTE) begin
                    m_in_image = 1'b1;
                    m_idx = 0;
                    m_sum = 8'd0;
                end
            end else begin
                if (m_idx == 0) begin
                    m_len_hi = rx_data;
                    m_sum ^= rx_data;
                end else if (m_idx == 1) begin
                    m_len = int'({m_len_hi, rx_data});
                    m_sum ^= rx_data;
                    if (m_len > int'(MAX_WORDS)) m_out = 2;
                end else if (m_idx < 2 + 2 * m_len) begin
                    m_sum ^= rx_data;
                    if ((m_idx - 2) % 2 == 0) begin
                        m_hi = rx_data;
                    end else begin
                        exp_addr_q.push_back((m_idx - 2) / 2);
                        exp_data_q.push_back({m_hi, rx_data});
                    end
                end else begin
                    m_out = (rx_data == m_sum) ? 1 : 2;
                end
                m_idx++;
            end
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    int          wr_addr_log[$];
    logic [15:0] wr_data_log[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_log.push_back(int'(mem_addr));
            wr_data_log.push_back(mem_wdata);
        end
        if (cmp_en) begin
            check("mem_we", {31'd0, mem_we}, {31'd0, exp_addr_q.size() != 0});
            if (mem_we === 1'b1 && exp_addr_q.size() != 0) begin
                m_last_addr = exp_addr_q[0][15:0];
                m_last_data = exp_data_q[0];
                exp_addr_q.pop_front();
                exp_data_q.pop_front();
            end
            check("mem_addr", {16'd0, mem_addr}, {16'd0, m_last_addr});
            check("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_last_data});
            check("rx_ready", {31'd0, rx_ready}, {31'd0, m_out == 0});
            check("done", {31'd0, done}, {31'd0, m_out == 1});
            check("error", {31'd0, error}, {31'd0, m_out == 2});
            check("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_out != 1});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // Drives bytes with optional idle gaps; abort_at asserts reset together
    // with that byte and stops the stream there.
    task automatic send(input byte_q_t bytes, input int gap_pct, input bit rnd_restart,
                        input int abort_at);
        for (int i = 0; i < bytes.size(); i++) begin
            for (int g = 0; g < 8 && $urandom_range(0, 99) < gap_pct; g++) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                restart  = rnd_restart && ($urandom_range(0, 7) == 0);
                tick();
            end
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            restart  = rnd_restart && ($urandom_range(0, 7) == 0);
            if (i == abort_at) reset = 1'b1;
            tick();
            if (i == abort_at) begin
                reset = 1'b0;
                break;
            end
        end
        rx_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rx_ready"}, {31'd0, rx_ready}, 32'd1);
        check({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, " mem_addr"}, {16'd0, mem_addr}, 32'd0);
        check({tag, " mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        check({tag, " cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic check_two_word_log(input string tag);
        check({tag, " nwrites"}, wr_addr_log.size(), 32'd2);
        if (wr_addr_log.size() == 2) begin
            check({tag, " addr0"}, wr_addr_log[0], 32'd0);
            check({tag, " data0"}, {16'd0, wr_data_log[0]}, 32'h1234);
            check({tag, " addr1"}, wr_addr_log[1], 32'd1);
            check({tag, " data1"}, {16'd0, wr_data_log[1]}, 32'hABCD);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t img;
        byte_q_t two_word;
        logic [7:0] ck;
        int len;
        int kind;

        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        restart = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("por");

        // Two-word image; the running XOR 00^02^12^34^AB^CD is 0x42.
        two_word = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        clear_log();
        send(two_word, 0, 1'b0, -1);
        check_two_word_log("img2");
        check("img2 done", {31'd0, done}, 32'd1);
        check("img2 cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("img2 rx_ready", {31'd0, rx_ready}, 32'd0);
        check("model cksum", {24'd0, m_sum}, 32'h42);
        pulse_restart();
        check("restart cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("restart done", {31'd0, done}, 32'd0);
        check("restart rx_ready", {31'd0, rx_ready}, 32'd1);

        // Same image with trailer 0x40 does not match the XOR, so it is rejected.
        clear_log();
        send('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 0, 1'b0, -1);
        check("bad40 error", {31'd0, error}, 32'd1);
        check("bad40 cpu_hold", {31'd0, cpu_hold}, 32'd1);
        pulse_restart();

        // Leading noise before sync.
        clear_log();
        send('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50}, 0, 1'b0, -1);
        check("noise nwrites", wr_addr_log.size(), 32'd1);
        if (wr_addr_log.size() == 1) begin
            check("noise addr0", wr_addr_log[0], 32'd0);
            check("noise data0", {16'd0, wr_data_log[0]}, 32'hBEEF);
        end
        check("noise done", {31'd0, done}, 32'd1);
        pulse_restart();

        // Empty image: good and bad checksum.
        clear_log();
        send('{8'hA5, 8'h00, 8'h00, 8'h00}, 0, 1'b0, -1);
        check("len0 nwrites", wr_addr_log.size(), 32'd0);
        check("len0 done", {31'd0, done}, 32'd1);
        pulse_restart();
        send('{8'hA5, 8'h00, 8'h00, 8'h01}, 0, 1'b0, -1);
        check("len0bad error", {31'd0, error}, 32'd1);
        check("len0bad cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("len0bad rx_ready", {31'd0, rx_ready}, 32'd0);
        pulse_restart();

        // LEN = 1025 is one past the limit: rejected right after the length.
        clear_log();
        send('{8'hA5, 8'h04, 8'h01}, 0, 1'b0, -1);
        check("over error", {31'd0, error}, 32'd1);
        check("over nwrites", wr_addr_log.size(), 32'd0);
        pulse_restart();
        clear_log();
        send(two_word, 0, 1'b0, -1);
        check("after-over done", {31'd0, done}, 32'd1);
        pulse_restart();

        // Random rx_valid gaps must not change the outcome.
        clear_log();
        send(two_word, 40, 1'b0, -1);
        check_two_word_log("gaps");
        check("gaps done", {31'd0, done}, 32'd1);
        pulse_restart();

        // Reset together with the first word's low byte cancels its write.
        send(two_word, 0, 1'b0, 4);
        check_reset_values("rst-coincident");
        // Reset after the first word has been written.
        send('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34}, 0, 1'b0, -1);
        tick();
        do_reset();
        check_reset_values("rst-midimage");
        clear_log();
        send(two_word, 0, 1'b0, -1);
        check("post-rst done", {31'd0, done}, 32'd1);
        pulse_restart();

        // Largest accepted image: LEN == MAX_WORDS.
        len = int'(MAX_WORDS);
        img = '{SYNC_BYTE, MAX_WORDS[15:8], MAX_WORDS[7:0]};
        ck = MAX_WORDS[15:8] ^ MAX_WORDS[7:0];
        for (int w = 0; w < 2 * len; w++) begin
            img.push_back(8'($urandom));
            ck ^= img[img.size() - 1];
        end
        img.push_back(ck);
        clear_log();
        send(img, 0, 1'b0, -1);
        check("max nwrites", wr_addr_log.size(), 32'd1024);
        if (wr_addr_log.size() == 1024)
            check("max last addr", wr_addr_log[1023], 32'd1023);
        check("max done", {31'd0, done}, 32'd1);
        pulse_restart();

        // Randomized images checked by the model every cycle.
        for (int it = 0; it < 40; it++) begin
            img.delete();
            for (int p = $urandom_range(0, 3); p > 0; p--) begin
                logic [7:0] junk;
                junk = 8'($urandom);
                if (junk == SYNC_BYTE) junk = 8'h00;
                img.push_back(junk);
            end
            kind = $urandom_range(0, 7);
            len = (kind == 7) ? $urandom_range(1025, 40000) : $urandom_range(0, 8);
            img.push_back(SYNC_BYTE);
            img.push_back(8'(len >> 8));
            img.push_back(8'(len));
            if (kind != 7) begin
                ck = 8'(len >> 8) ^ 8'(len);
                for (int w = 0; w < 2 * len; w++) begin
                    img.push_back(8'($urandom));
                    ck ^= img[img.size() - 1];
                end
                img.push_back((kind == 6) ? ~ck : ck);
            end
            for (int t = $urandom_range(0, 2); t > 0; t--) img.push_back(8'($urandom));
            send(img, $urandom_range(0, 50), 1'b1,
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : -1);
            tick();
            pulse_restart();
        end

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
